// File: rtl/exe_mem_stage.sv
// EXE->MEM pipeline register: valid/ready handshake with a two-entry skid buffer,
// flush-to-bubble, a forwarding tap for the hazard unit and a saturating stall counter.
//
// state | meaning
// EMPTY | no entry held, main and skid invalid
// ONE   | main entry valid and driving the outputs
// FULL  | main and skid both valid, upstream held off
module exe_mem_stage #(
    parameter int WORD_WIDTH     = 32,
    parameter int REG_FILE_DEPTH = 4,
    parameter int STALL_CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD_WIDTH-1:0]     pc_in,
    input  logic [WORD_WIDTH-1:0]     instruction_in,
    input  logic [WORD_WIDTH-1:0]     ALU_res_in,
    input  logic [WORD_WIDTH-1:0]     val_Rm_in,
    input  logic [REG_FILE_DEPTH-1:0] dst_in,
    input  logic                      mem_read_in,
    input  logic                      mem_write_in,
    input  logic                      WB_en_in,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORD_WIDTH-1:0]     pc,
    output logic [WORD_WIDTH-1:0]     instruction,
    output logic [WORD_WIDTH-1:0]     ALU_res_out,
    output logic [WORD_WIDTH-1:0]     val_Rm_out,
    output logic [REG_FILE_DEPTH-1:0] dst_out,
    output logic                      mem_read_out,
    output logic                      mem_write_out,
    output logic                      WB_en_out,
    output logic                      fwd_valid,
    output logic [REG_FILE_DEPTH-1:0] fwd_dst,
    output logic [WORD_WIDTH-1:0]     fwd_data,
    output logic [STALL_CNT_W-1:0]    stall_cnt,
    input  logic                      stall_cnt_clr
);

    typedef struct packed {
        logic [WORD_WIDTH-1:0]     pc;
        logic [WORD_WIDTH-1:0]     instruction;
        logic [WORD_WIDTH-1:0]     alu_res;
        logic [WORD_WIDTH-1:0]     val_rm;
        logic [REG_FILE_DEPTH-1:0] dst;
        logic                      mem_read;
        logic                      mem_write;
        logic                      wb_en;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    state_t state_q;
    state_t state_d;
    entry_t m_q;
    entry_t s_q;
    entry_t in_e;
    logic   accept;
    logic   pop;
    logic   load_m;
    logic   load_s;
    logic   m_from_s;

    assign in_e = '{
        pc:          pc_in,
        instruction: instruction_in,
        alu_res:     ALU_res_in,
        val_rm:      val_Rm_in,
        dst:         dst_in,
        mem_read:    mem_read_in,
        mem_write:   mem_write_in,
        wb_en:       WB_en_in
    };

    // in_ready comes from registered state only, keeping out_ready off the upstream path
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        load_m   = 1'b0;
        load_s   = 1'b0;
        m_from_s = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    load_m  = 1'b1;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    load_m = 1'b1;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end else if (accept) begin
                    load_s  = 1'b1;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    m_from_s = 1'b1;
                    state_d  = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // a pop in the flush cycle has already been taken downstream; everything else is dropped
        if (flush) begin
            state_d  = ST_EMPTY;
            load_m   = 1'b0;
            load_s   = 1'b0;
            m_from_s = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q <= '0;
            s_q <= '0;
        end else begin
            if (load_m) begin
                m_q <= in_e;
            end else if (m_from_s) begin
                m_q <= s_q;
            end
            if (load_s) begin
                s_q <= in_e;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall_cnt_clr) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != STALL_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign pc            = m_q.pc;
    assign instruction   = m_q.instruction;
    assign ALU_res_out   = m_q.alu_res;
    assign val_Rm_out    = m_q.val_rm;
    assign dst_out       = m_q.dst;
    assign mem_read_out  = out_valid && m_q.mem_read;
    assign mem_write_out = out_valid && m_q.mem_write;
    assign WB_en_out     = out_valid && m_q.wb_en;

    // loads produce their value in MEM, so they are never offered for forwarding
    assign fwd_valid = out_valid && WB_en_out && !mem_read_out;
    assign fwd_dst   = dst_out;
    assign fwd_data  = ALU_res_out;

endmodule

// File: tb/tb_exe_mem_stage.sv
// Scoreboard bench for exe_mem_stage: a queue of expected entries models the stage,
// directed scenarios plus randomized traffic drive it.
module tb_exe_mem_stage;

    localparam int WW   = 32;
    localparam int RD   = 4;
    localparam int SW   = 4;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [WW-1:0] pc_in, instruction_in, ALU_res_in, val_Rm_in;
    logic [RD-1:0] dst_in;
    logic          mem_read_in, mem_write_in, WB_en_in;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [WW-1:0] pc, instruction, ALU_res_out, val_Rm_out;
    logic [RD-1:0] dst_out;
    logic          mem_read_out, mem_write_out, WB_en_out;
    logic          fwd_valid;
    logic [RD-1:0] fwd_dst;
    logic [WW-1:0] fwd_data;
    logic [SW-1:0] stall_cnt;
    logic          stall_cnt_clr;

    exe_mem_stage #(.WORD_WIDTH(WW), .REG_FILE_DEPTH(RD), .STALL_CNT_W(SW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .instruction_in(instruction_in), .ALU_res_in(ALU_res_in),
        .val_Rm_in(val_Rm_in), .dst_in(dst_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .WB_en_in(WB_en_in),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .pc(pc), .instruction(instruction), .ALU_res_out(ALU_res_out),
        .val_Rm_out(val_Rm_out), .dst_out(dst_out),
        .mem_read_out(mem_read_out), .mem_write_out(mem_write_out), .WB_en_out(WB_en_out),
        .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data),
        .stall_cnt(stall_cnt), .stall_cnt_clr(stall_cnt_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0] pc, ins, alu, rm;
        logic [RD-1:0] dst;
        logic          mr, mw, wb;
    } ent_t;

    ent_t q[$];
    ent_t h;
    ent_t cur;
    int   n;
    int   stall_m = 0;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // sampled mid-cycle: compare against the queue head, then apply this cycle's transfers
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            stall_m = 0;
        end else begin
            n = q.size();
            chk("out_valid", out_valid, (n > 0));
            chk("in_ready", in_ready, (n < 2));
            chk("stall_cnt", stall_cnt, stall_m);
            if (n > 0) begin
                h = q[0];
                chk("pc", pc, h.pc);
                chk("instruction", instruction, h.ins);
                chk("alu_res", ALU_res_out, h.alu);
                chk("val_rm", val_Rm_out, h.rm);
                chk("dst", dst_out, h.dst);
                chk("mem_read", mem_read_out, h.mr);
                chk("mem_write", mem_write_out, h.mw);
                chk("wb_en", WB_en_out, h.wb);
                chk("fwd_valid", fwd_valid, h.wb && !h.mr);
                if (h.wb && !h.mr) begin
                    chk("fwd_dst", fwd_dst, h.dst);
                    chk("fwd_data", fwd_data, h.alu);
                end
            end else begin
                chk("idle_ctrl", {mem_read_out, mem_write_out, WB_en_out, fwd_valid}, 4'b0);
            end
            if (stall_cnt_clr) stall_m = 0;
            else if (n > 0 && !out_ready && stall_m < SMAX) stall_m++;
            if (n > 0 && out_ready) void'(q.pop_front());
            if (in_valid && n < 2 && !flush) begin
                cur.pc = pc_in; cur.ins = instruction_in; cur.alu = ALU_res_in; cur.rm = val_Rm_in;
                cur.dst = dst_in; cur.mr = mem_read_in; cur.mw = mem_write_in; cur.wb = WB_en_in;
                q.push_back(cur);
            end
            if (flush) q.delete();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic iv, input logic [WW-1:0] p, input logic [RD-1:0] d,
                          input logic [WW-1:0] alu, input logic mr, input logic mw, input logic wb);
        in_valid       = iv;
        pc_in          = p;
        instruction_in = $urandom;
        ALU_res_in     = alu;
        val_Rm_in      = $urandom;
        dst_in         = d;
        mem_read_in    = mr;
        mem_write_in   = mw;
        WB_en_in       = wb;
    endtask

    task automatic drain();
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1; flush = 1'b0; stall_cnt_clr = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b0;
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0; flush = 1'b0; stall_cnt_clr = 1'b0;
        #12 rst = 1'b1;
        tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_pc", pc, 32'h0);
        chk("rst_alu", ALU_res_out, 32'h0);
        chk("rst_fwd_valid", fwd_valid, 1'b0);
        chk("rst_stall", stall_cnt, 4'h0);

        // stream of four with downstream always ready
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'(i * 4), 4'(i), $urandom, 1'b0, 1'($urandom), 1'b1);
            tick();
            chk("stream_valid", out_valid, 1'b1);
            chk("stream_pc", pc, 32'(i * 4));
        end
        drain();

        // back-pressure: third entry must wait until the stage drains
        stall_cnt_clr = 1'b1; out_ready = 1'b0;
        set_in(1'b1, 32'h10, 4'h1, $urandom, 1'b0, 1'b0, 1'b1);
        tick();
        stall_cnt_clr = 1'b0;
        set_in(1'b1, 32'h14, 4'h2, $urandom, 1'b0, 1'b1, 1'b0);
        tick();
        chk("bp_in_ready_low", in_ready, 1'b0);
        set_in(1'b1, 32'h18, 4'h3, $urandom, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        chk("bp_stall_cnt", stall_cnt, 4'd3);
        chk("bp_head", pc, 32'h10);
        out_ready = 1'b1;
        tick();
        chk("bp_second", pc, 32'h14);
        chk("bp_in_ready_back", in_ready, 1'b1);
        tick();
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("bp_third", pc, 32'h18);
        drain();

        // flush while FULL with a pop and a new input in the same cycle
        out_ready = 1'b0;
        set_in(1'b1, 32'h20, 4'h4, $urandom, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 32'h24, 4'h5, $urandom, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 32'h28, 4'h6, $urandom, 1'b0, 1'b1, 1'b1);
        out_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_mem_write", mem_write_out, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        drain();

        // forwarding tap: ALU result forwarded, load result not
        out_ready = 1'b0;
        set_in(1'b1, 32'h30, 4'd3, 32'hDEAD, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("fwd_alu_valid", fwd_valid, 1'b1);
        chk("fwd_alu_dst", fwd_dst, 4'd3);
        chk("fwd_alu_data", fwd_data, 32'hDEAD);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        set_in(1'b1, 32'h30, 4'd3, 32'hDEAD, 1'b1, 1'b0, 1'b1);
        tick();
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("fwd_load_valid", fwd_valid, 1'b0);

        // saturation, then clear while still stalled
        repeat (20) tick();
        chk("sat_stall_cnt", stall_cnt, 4'd15);
        stall_cnt_clr = 1'b1;
        tick();
        stall_cnt_clr = 1'b0;
        chk("clr_stall_cnt", stall_cnt, 4'd0);
        drain();

        // asynchronous reset between edges while FULL
        out_ready = 1'b0;
        set_in(1'b1, 32'h40, 4'h7, $urandom, 1'b0, 1'b1, 1'b1);
        tick();
        set_in(1'b1, 32'h44, 4'h8, $urandom, 1'b0, 1'b1, 1'b1);
        tick();
        set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_ctrl", {mem_read_out, mem_write_out, WB_en_out, fwd_valid}, 4'b0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_stall", stall_cnt, 4'h0);
        @(negedge clk);
        #1 rst = 1'b1;
        tick();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), $urandom, 4'($urandom), $urandom,
                   1'($urandom), 1'($urandom), 1'($urandom));
            out_ready     = ($urandom_range(0, 9) < 6);
            flush         = ($urandom_range(0, 19) == 0);
            stall_cnt_clr = ($urandom_range(0, 29) == 0);
            tick();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
